// File: rtl/pulse_symbol_decoder_pkg.sv
// Shared types and constants for the long/short pulse decoding path.
// TICK_W is also used by tick_generator, so both agree on the duration width.
package pulse_pkg;

    localparam int TICK_W = 15;

    localparam logic SYM_SHORT = 1'b0;
    localparam logic SYM_LONG  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        EVAL,
        GAP,
        EMIT
    } state_t;

    // Saturated durations (all ones) land on the long side naturally.
    function automatic logic classify_sym(input logic [TICK_W-1:0] ticks,
                                          input logic [TICK_W-1:0] long_min);
        return (ticks >= long_min) ? SYM_LONG : SYM_SHORT;
    endfunction

endpackage

// File: rtl/pulse_symbol_decoder_gap_timer.sv
// Quiet-gap timer: a clk prescaler that advances a saturating TICK_W-bit
// counter once every DIV enabled cycles. i_clr has priority over i_en.
module gap_timer
    import pulse_pkg::*;
#(
    parameter int DIV = 25000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [TICK_W-1:0] o_count
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0]     r_presc;
    logic [TICK_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_presc <= '0;
            r_count <= '0;
        end else if (i_en) begin
            if (r_presc == PRESC_LAST) begin
                r_presc <= '0;
                if (r_count != '1)
                    r_count <= r_count + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pulse_symbol_decoder.sv
// Classifies button/line presses as glitch/short/long from tick_total, packs
// symbols into a character, and emits the character after a quiet gap.
module pulse_symbol_decoder
    import pulse_pkg::*;
#(
    parameter logic [TICK_W-1:0] SHORT_MIN = 15'd50,
    parameter logic [TICK_W-1:0] LONG_MIN  = 15'd300,
    parameter int                GAP_DIV   = 25000,
    parameter logic [TICK_W-1:0] CHAR_GAP  = 15'd700,
    parameter int                MAX_SYM   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [TICK_W-1:0]  tick_total,
    output logic               char_valid,
    output logic [MAX_SYM-1:0] char_bits,
    output logic [2:0]         char_len,
    output logic               char_err,
    output logic               sym_strobe,
    output logic               sym_long,
    output logic               busy
);

    localparam logic [2:0] LEN_MAX = 3'(MAX_SYM);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_start_q;
    logic [TICK_W-1:0]  r_tick;
    logic [MAX_SYM-1:0] r_bits;
    logic [2:0]         r_len;
    logic               r_err;
    logic               r_sym_strobe;
    logic               r_sym_long;
    logic [MAX_SYM-1:0] r_char_bits;
    logic [2:0]         r_char_len;
    logic               r_char_err;

    logic               w_release;
    logic               w_capture;
    logic               w_accept;
    logic               w_sym;
    logic [MAX_SYM-1:0] w_bits_shifted;
    logic               w_gap_clr;
    logic               w_gap_en;
    logic [TICK_W-1:0]  w_gap_count;

    assign w_release = r_start_q & ~start;
    // A one-cycle press can release while IDLE (press began in EMIT) or GAP
    // (press began in EVAL); sample it there too so no symbol is dropped.
    assign w_capture = w_release &&
                       (r_state == PRESS || r_state == IDLE || r_state == GAP);
    assign w_accept  = (r_tick >= SHORT_MIN);
    assign w_sym     = classify_sym(r_tick, LONG_MIN);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_SYM; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign w_bits_shifted[gi] = w_sym;
            end else begin : g_up
                assign w_bits_shifted[gi] = r_bits[gi-1];
            end
        end
    endgenerate

    // Gap timing starts in EVAL so char_valid lands exactly
    // CHAR_GAP*GAP_DIV+2 cycles after the release cycle.
    assign w_gap_en  = (r_state == EVAL) || (r_state == GAP);
    assign w_gap_clr = !w_gap_en || start || w_release;

    gap_timer #(
        .DIV (GAP_DIV)
    ) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_gap_clr),
        .i_en    (w_gap_en),
        .o_count (w_gap_count)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_release)
                    w_state_next = EVAL;
                else if (start)
                    w_state_next = PRESS;
            end
            PRESS: begin
                if (w_release)
                    w_state_next = EVAL;
            end
            EVAL: begin
                if (w_accept || r_len != 3'd0 || r_err)
                    w_state_next = GAP;
                else
                    w_state_next = IDLE;
            end
            GAP: begin
                if (w_release)
                    w_state_next = EVAL;
                else if (start)
                    w_state_next = PRESS;
                else if (w_gap_count == CHAR_GAP)
                    w_state_next = EMIT;
            end
            EMIT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_q    <= 1'b0;
            r_tick       <= '0;
            r_bits       <= '0;
            r_len        <= 3'd0;
            r_err        <= 1'b0;
            r_sym_strobe <= 1'b0;
            r_sym_long   <= 1'b0;
            r_char_bits  <= '0;
            r_char_len   <= 3'd0;
            r_char_err   <= 1'b0;
        end else begin
            r_start_q    <= start;
            r_sym_strobe <= 1'b0;

            if (w_capture)
                r_tick <= tick_total;

            if (r_state == EVAL && w_accept) begin
                r_sym_strobe <= 1'b1;
                r_sym_long   <= w_sym;
                if (r_len < LEN_MAX) begin
                    r_bits <= w_bits_shifted;
                    r_len  <= r_len + 3'd1;
                end else begin
                    r_err  <= 1'b1;
                end
            end

            // Character outputs are loaded on entry to EMIT and then held.
            if (r_state == GAP && w_state_next == EMIT) begin
                r_char_bits <= r_bits;
                r_char_len  <= r_len;
                r_char_err  <= r_err;
            end

            if (r_state == EMIT) begin
                r_bits <= '0;
                r_len  <= 3'd0;
                r_err  <= 1'b0;
            end
        end
    end

    assign char_valid = (r_state == EMIT);
    assign char_bits  = r_char_bits;
    assign char_len   = r_char_len;
    assign char_err   = r_char_err;
    assign sym_strobe = r_sym_strobe;
    assign sym_long   = r_sym_long;
    assign busy       = (r_len != 3'd0 || r_err) && (r_state != IDLE);

endmodule
